// File: rtl/mem_ss_pkg.sv
// Memory subsystem shared types and constants.
// Holds the DDR4 alert monitor state/event encodings and default thresholds.
package mem_ss_pkg;

    // Alert pulse measurement states
    typedef enum logic [1:0] {
        ALERT_IDLE  = 2'd0,
        ALERT_MEAS  = 2'd1,
        ALERT_STUCK = 2'd2
    } ddr4_alert_state_e;

    // Classified alert event types, encoded as reported on evt_type
    typedef enum logic [1:0] {
        EVT_GLITCH = 2'd0,
        EVT_CRC    = 2'd1,
        EVT_PAR    = 2'd2,
        EVT_STUCK  = 2'd3
    } ddr4_alert_evt_e;

    // Default classification thresholds, in synchronized clk cycles
    localparam int DDR4_ALERT_MIN_W     = 2;
    localparam int DDR4_ALERT_CRC_MAX_W = 6;
    localparam int DDR4_ALERT_STUCK_W   = 4096;

endpackage

// File: rtl/ddr4_alert_sync.sv
// Multi-flop synchronizer for the asynchronous DDR4 alert_n pin.
// Flops reset to 1 so a reset never looks like an alert pulse.
module ddr4_alert_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    (* async_reg = "true" *) logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw pin through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ddr4_alert_monitor.sv
// DDR4 alert_n pulse classifier: measures each low pulse of the synchronized
// alert pin and reports it as glitch, write-CRC, CA-parity or stuck-low.
// Optional feature macro: OFS_FIM_DDR4_ALERT_TS_EN adds a free-running cycle
// counter and the last_ts output capturing its value on non-glitch events.
module ddr4_alert_monitor
    import mem_ss_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_W       = DDR4_ALERT_MIN_W,
    parameter int CRC_MAX_W   = DDR4_ALERT_CRC_MAX_W,
    parameter int STUCK_W     = DDR4_ALERT_STUCK_W,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alert_n,
    input  logic             mon_en,
    input  logic             clr,
    input  logic [2:0]       irq_mask,
    output logic [CNT_W-1:0] crc_cnt,
    output logic [CNT_W-1:0] par_cnt,
    output logic [CNT_W-1:0] glitch_cnt,
    output logic [2:0]       sticky,
    output logic             stuck,
    output logic             evt_vld,
    output logic [1:0]       evt_type,
`ifdef OFS_FIM_DDR4_ALERT_TS_EN
    output logic [31:0]      last_ts,
`endif
    output logic             irq
);

    localparam int WW = $clog2(STUCK_W + 1);

    localparam logic [WW-1:0] MIN_V      = WW'(MIN_W);
    localparam logic [WW-1:0] CRC_MAX_V  = WW'(CRC_MAX_W);
    localparam logic [WW-1:0] STUCK_V    = WW'(STUCK_W);
    localparam logic [WW-1:0] STUCK_M1_V = WW'(STUCK_W - 1);

    logic              a_s;
    ddr4_alert_state_e state_q, state_d;
    logic [WW-1:0]     width_q, width_d;
    logic              evt_now;
    ddr4_alert_evt_e   evt_type_d;
    ddr4_alert_evt_e   evt_type_q;
    logic              evt_vld_q;
    logic [CNT_W-1:0]  crc_q, par_q, glitch_q;
    logic [2:0]        sticky_q;
    logic [2:0]        sticky_hit;
    logic              irq_q;

    ddr4_alert_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (alert_n),
        .dout (a_s)
    );

    // FSM state and pulse width registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ALERT_IDLE;
            width_q <= '0;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
        end
    end

    // Next-state logic; the width count includes the cycle that started the pulse
    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        evt_now    = 1'b0;
        evt_type_d = EVT_GLITCH;
        case (state_q)
            ALERT_IDLE: begin
                width_d = '0;
                if (mon_en && !a_s) begin
                    state_d = ALERT_MEAS;
                    width_d = WW'(1);
                end
            end
            ALERT_MEAS: begin
                if (!mon_en) begin
                    state_d = ALERT_IDLE;
                    width_d = '0;
                end else if (a_s) begin
                    state_d = ALERT_IDLE;
                    width_d = '0;
                    evt_now = 1'b1;
                    if (width_q < MIN_V) begin
                        evt_type_d = EVT_GLITCH;
                    end else if (width_q <= CRC_MAX_V) begin
                        evt_type_d = EVT_CRC;
                    end else begin
                        evt_type_d = EVT_PAR;
                    end
                end else if (width_q >= STUCK_M1_V) begin
                    state_d    = ALERT_STUCK;
                    width_d    = STUCK_V;
                    evt_now    = 1'b1;
                    evt_type_d = EVT_STUCK;
                end else begin
                    width_d = width_q + WW'(1);
                end
            end
            ALERT_STUCK: begin
                if (!mon_en || a_s) begin
                    state_d = ALERT_IDLE;
                    width_d = '0;
                end
            end
            default: begin
                state_d = ALERT_IDLE;
                width_d = '0;
            end
        endcase
    end

    assign sticky_hit = {evt_now && (evt_type_d == EVT_STUCK),
                         evt_now && (evt_type_d == EVT_PAR),
                         evt_now && (evt_type_d == EVT_CRC)};

    // Event pulse and type, registered one cycle after classification
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_vld_q  <= 1'b0;
            evt_type_q <= EVT_GLITCH;
        end else begin
            evt_vld_q  <= evt_now;
            evt_type_q <= evt_now ? evt_type_d : EVT_GLITCH;
        end
    end

    // Saturating event counters; an event coincident with clr still counts once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q    <= '0;
            par_q    <= '0;
            glitch_q <= '0;
        end else if (clr) begin
            crc_q    <= (evt_now && evt_type_d == EVT_CRC)    ? CNT_W'(1) : '0;
            par_q    <= (evt_now && evt_type_d == EVT_PAR)    ? CNT_W'(1) : '0;
            glitch_q <= (evt_now && evt_type_d == EVT_GLITCH) ? CNT_W'(1) : '0;
        end else if (evt_now) begin
            if (evt_type_d == EVT_CRC && !(&crc_q)) begin
                crc_q <= crc_q + CNT_W'(1);
            end
            if (evt_type_d == EVT_PAR && !(&par_q)) begin
                par_q <= par_q + CNT_W'(1);
            end
            if (evt_type_d == EVT_GLITCH && !(&glitch_q)) begin
                glitch_q <= glitch_q + CNT_W'(1);
            end
        end
    end

    // Sticky flags {stuck, par, crc}; clr wins over old state but not over a new hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else if (clr) begin
            sticky_q <= sticky_hit;
        end else begin
            sticky_q <= sticky_q | sticky_hit;
        end
    end

    // Interrupt from unmasked sticky flags, one cycle behind sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(sticky_q & ~irq_mask);
        end
    end

`ifdef OFS_FIM_DDR4_ALERT_TS_EN
    logic [31:0] ts_q;
    logic [31:0] last_ts_q;

    // Free-running timestamp; last_ts holds the value current during evt_vld
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q      <= '0;
            last_ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (evt_now && evt_type_d != EVT_GLITCH) begin
                last_ts_q <= ts_q + 32'd1;
            end
        end
    end

    assign last_ts = last_ts_q;
`endif

    assign crc_cnt    = crc_q;
    assign par_cnt    = par_q;
    assign glitch_cnt = glitch_q;
    assign sticky     = sticky_q;
    assign stuck      = (state_q == ALERT_STUCK);
    assign evt_vld    = evt_vld_q;
    assign evt_type   = evt_type_q;
    assign irq        = irq_q;

endmodule
